// File: rtl/riscv_mc_ctrl_pkg.sv
// rtl/riscv_mc_ctrl_pkg.sv - shared encodings for the multicycle RV32I controller
//
// Holds the RV32I opcodes, the 4-bit FSM state encoding, immediate-type codes,
// ALU operation codes and datapath select codes shared by riscv_mc_ctrl and
// riscv_mc_ctrl_aludec. Also holds two opcode decode helpers.

package riscv_mc_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL_LINK = 4'd11,
        S_JALR_TGT = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    localparam logic [1:0] ALU_A_PC    = 2'd0;
    localparam logic [1:0] ALU_A_OLDPC = 2'd1;
    localparam logic [1:0] ALU_A_RS1   = 2'd2;

    localparam logic [1:0] ALU_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_B_IMM  = 2'd1;
    localparam logic [1:0] ALU_B_FOUR = 2'd2;

    localparam logic [1:0] RD_ALUOUT = 2'd0;
    localparam logic [1:0] RD_MDR    = 2'd1;
    localparam logic [1:0] RD_ALURES = 2'd2;
    localparam logic [1:0] RD_IMM    = 2'd3;

    // Immediate flavour used in DECODE, where the ALU precomputes OldPC+imm.
    function automatic logic [2:0] decode_imm_type(input logic [6:0] op);
        case (op)
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_AUIPC:  return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

    function automatic logic opcode_known(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_OP, OP_IMM, OP_BRANCH, OP_JAL,
            OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_ctrl_aludec.sv
// rtl/riscv_mc_ctrl_aludec.sv - ALU operation decoder for the multicycle controller
//
// Purely combinational: maps FSM state plus funct3/funct7[5] to the ALU code.
// Ports:
//   state     in  4  current controller state (state_t encoding)
//   funct3    in  3  instruction funct3
//   funct7_b5 in  1  instruction bit 30
//   alu_ctrl  out 4  {funct7[5],funct3}-style ALU operation code

module riscv_mc_ctrl_aludec
    import riscv_mc_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (state_t'(state))
            S_EXECR: alu_ctrl = {funct7_b5, funct3};
            // Bit 30 of an I-type is immediate data except for SRLI/SRAI.
            S_EXECI: alu_ctrl = {(funct3 == 3'b101) & funct7_b5, funct3};
            S_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   alu_ctrl = ALU_SLT;
                    2'b11:   alu_ctrl = ALU_SLTU;
                    default: alu_ctrl = ALU_SUB;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// rtl/riscv_mc_ctrl.sv - multicycle RV32I controller FSM
//
// Sequences a shared-ALU, single-memory datapath (IR, OldPC, A/B, ALUOut, MDR).
// Outputs are Moore-decoded from state; only FETCH/MEMREAD/MEMWRITE ready
// gating and the branch-taken gating of pc_wr_en depend on inputs.
// Ports:
//   i_clk, i_rstn        clock / asynchronous active-low reset
//   i_ctrl_instr    32   latched IR contents
//   i_ctrl_alu_zero 1    ALU zero flag
//   i_ctrl_mem_ready 1   memory completes current request
//   o_ctrl_mem_req, o_ctrl_mem_wr_en, o_ctrl_adr_src   memory handshake/address
//   o_ctrl_ir_wr_en, o_ctrl_pc_wr_en, o_ctrl_src_pc    IR/PC updates
//   o_ctrl_src_alu_a/b, o_ctrl_src_imm, o_ctrl_alu_ctrl ALU operand/op selects
//   o_ctrl_src_rd, o_ctrl_reg_wr_en                    register writeback
//   o_ctrl_illegal, o_ctrl_mem_err                     one-cycle error pulses
// MEM_TIMEOUT: 0 waits forever, N aborts after N cycles without ready.

module riscv_mc_ctrl
    import riscv_mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_ctrl_instr,
    input  logic        i_ctrl_alu_zero,
    input  logic        i_ctrl_mem_ready,
    output logic        o_ctrl_mem_req,
    output logic        o_ctrl_mem_wr_en,
    output logic        o_ctrl_adr_src,
    output logic        o_ctrl_ir_wr_en,
    output logic        o_ctrl_pc_wr_en,
    output logic        o_ctrl_src_pc,
    output logic [1:0]  o_ctrl_src_alu_a,
    output logic [1:0]  o_ctrl_src_alu_b,
    output logic [2:0]  o_ctrl_src_imm,
    output logic [3:0]  o_ctrl_alu_ctrl,
    output logic [1:0]  o_ctrl_src_rd,
    output logic        o_ctrl_reg_wr_en,
    output logic        o_ctrl_illegal,
    output logic        o_ctrl_mem_err
);

    localparam bit         TO_EN   = (MEM_TIMEOUT > 0);
    localparam logic [7:0] TO_LAST = TO_EN ? 8'(MEM_TIMEOUT - 1) : 8'd0;

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       mem_phase;
    logic       timeout;
    logic       br_taken;
    logic       unused_instr_bits;

    assign opcode    = i_ctrl_instr[6:0];
    assign funct3    = i_ctrl_instr[14:12];
    assign funct7_b5 = i_ctrl_instr[30];
    assign unused_instr_bits = ^{i_ctrl_instr[31], i_ctrl_instr[29:15], i_ctrl_instr[11:7]};

    // Only these states drive mem_req, so ready is only looked at here.
    assign mem_phase = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout   = TO_EN && mem_phase && !i_ctrl_mem_ready && (wait_cnt == TO_LAST);

    // SUB/SLT/SLTU leave the comparison in zero; f3[2] picks lt vs eq, f3[0] inverts.
    assign br_taken = (funct3[2] ? ~i_ctrl_alu_zero : i_ctrl_alu_zero) ^ funct3[0];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Timeout also clears the count so a re-entered FETCH starts a fresh wait.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wait_cnt <= 8'd0;
        end else if (timeout || !mem_phase || (next_state != state)) begin
            wait_cnt <= 8'd0;
        end else if (!i_ctrl_mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: begin
                if (timeout)               next_state = S_FETCH;
                else if (i_ctrl_mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_OP:             next_state = S_EXECR;
                    OP_IMM:            next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL_LINK;
                    OP_JALR:           next_state = S_JALR_TGT;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_ALUWB;
                    default:           next_state = S_FETCH;
                endcase
            end
            // Store and load opcodes differ only in bit 5.
            S_MEMADR: next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (timeout)               next_state = S_FETCH;
                else if (i_ctrl_mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: next_state = S_FETCH;
            S_MEMWRITE: begin
                if (timeout || i_ctrl_mem_ready) next_state = S_FETCH;
            end
            S_EXECR, S_EXECI: next_state = S_ALUWB;
            S_ALUWB:          next_state = S_FETCH;
            S_BRANCH:         next_state = S_FETCH;
            S_JAL_LINK:       next_state = S_FETCH;
            S_JALR_TGT:       next_state = S_JAL_LINK;
            S_LUI:            next_state = S_FETCH;
            default:          next_state = S_FETCH;
        endcase
    end

    riscv_mc_ctrl_aludec u_aludec (
        .state     (state),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .alu_ctrl  (o_ctrl_alu_ctrl)
    );

    always_comb begin
        o_ctrl_mem_req   = 1'b0;
        o_ctrl_mem_wr_en = 1'b0;
        o_ctrl_adr_src   = 1'b0;
        o_ctrl_ir_wr_en  = 1'b0;
        o_ctrl_pc_wr_en  = 1'b0;
        o_ctrl_src_pc    = 1'b0;
        o_ctrl_src_alu_a = ALU_A_PC;
        o_ctrl_src_alu_b = ALU_B_RS2;
        o_ctrl_src_imm   = IMM_I;
        o_ctrl_src_rd    = RD_ALUOUT;
        o_ctrl_reg_wr_en = 1'b0;
        o_ctrl_illegal   = 1'b0;
        o_ctrl_mem_err   = timeout;
        case (state)
            S_FETCH: begin
                o_ctrl_mem_req   = 1'b1;
                o_ctrl_src_alu_b = ALU_B_FOUR;
                o_ctrl_ir_wr_en  = i_ctrl_mem_ready;
                o_ctrl_pc_wr_en  = i_ctrl_mem_ready;
            end
            S_DECODE: begin
                o_ctrl_src_alu_a = ALU_A_OLDPC;
                o_ctrl_src_alu_b = ALU_B_IMM;
                o_ctrl_src_imm   = decode_imm_type(opcode);
                o_ctrl_illegal   = !opcode_known(opcode);
            end
            S_MEMADR: begin
                o_ctrl_src_alu_a = ALU_A_RS1;
                o_ctrl_src_alu_b = ALU_B_IMM;
                o_ctrl_src_imm   = opcode[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                o_ctrl_mem_req = 1'b1;
                o_ctrl_adr_src = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl_src_rd    = RD_MDR;
                o_ctrl_reg_wr_en = 1'b1;
            end
            S_MEMWRITE: begin
                o_ctrl_mem_req   = 1'b1;
                o_ctrl_mem_wr_en = 1'b1;
                o_ctrl_adr_src   = 1'b1;
            end
            S_EXECR: begin
                o_ctrl_src_alu_a = ALU_A_RS1;
                o_ctrl_src_alu_b = ALU_B_RS2;
            end
            S_EXECI, S_JALR_TGT: begin
                o_ctrl_src_alu_a = ALU_A_RS1;
                o_ctrl_src_alu_b = ALU_B_IMM;
            end
            S_ALUWB: begin
                o_ctrl_src_rd    = RD_ALUOUT;
                o_ctrl_reg_wr_en = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl_src_alu_a = ALU_A_RS1;
                o_ctrl_src_alu_b = ALU_B_RS2;
                o_ctrl_pc_wr_en  = br_taken;
                o_ctrl_src_pc    = 1'b1;
            end
            S_JAL_LINK: begin
                o_ctrl_src_alu_a = ALU_A_OLDPC;
                o_ctrl_src_alu_b = ALU_B_FOUR;
                o_ctrl_src_rd    = RD_ALURES;
                o_ctrl_reg_wr_en = 1'b1;
                o_ctrl_pc_wr_en  = 1'b1;
                o_ctrl_src_pc    = 1'b1;
            end
            S_LUI: begin
                o_ctrl_src_imm   = IMM_U;
                o_ctrl_src_rd    = RD_IMM;
                o_ctrl_reg_wr_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb/tb_riscv_mc_ctrl.sv - directed self-checking bench for riscv_mc_ctrl

module tb_riscv_mc_ctrl;

    // Packed view: {mem_req, mem_wr_en, adr_src, ir_wr_en, pc_wr_en, src_pc,
    //               alu_a[2], alu_b[2], imm[3], alu_ctrl[4], src_rd[2],
    //               reg_wr_en, illegal, mem_err}
    localparam logic [21:0] F_RDY    = {6'b100110, 2'd0, 2'd2, 3'd0, 4'b0000, 2'd0, 3'b000};
    localparam logic [21:0] F_WAIT   = {6'b100000, 2'd0, 2'd2, 3'd0, 4'b0000, 2'd0, 3'b000};
    localparam logic [21:0] F_TOUT   = {6'b100000, 2'd0, 2'd2, 3'd0, 4'b0000, 2'd0, 3'b001};
    localparam logic [21:0] DEC_I    = {6'b000000, 2'd1, 2'd1, 3'd0, 4'b0000, 2'd0, 3'b000};
    localparam logic [21:0] DEC_B    = {6'b000000, 2'd1, 2'd1, 3'd2, 4'b0000, 2'd0, 3'b000};
    localparam logic [21:0] DEC_J    = {6'b000000, 2'd1, 2'd1, 3'd3, 4'b0000, 2'd0, 3'b000};
    localparam logic [21:0] DEC_U    = {6'b000000, 2'd1, 2'd1, 3'd4, 4'b0000, 2'd0, 3'b000};
    localparam logic [21:0] DEC_ILL  = {6'b000000, 2'd1, 2'd1, 3'd0, 4'b0000, 2'd0, 3'b010};
    localparam logic [21:0] EXR_ADD  = {6'b000000, 2'd2, 2'd0, 3'd0, 4'b0000, 2'd0, 3'b000};
    localparam logic [21:0] EXI_SRAI = {6'b000000, 2'd2, 2'd1, 3'd0, 4'b1101, 2'd0, 3'b000};
    localparam logic [21:0] EXI_ADDI = {6'b000000, 2'd2, 2'd1, 3'd0, 4'b0000, 2'd0, 3'b000};
    localparam logic [21:0] ALUWB    = {6'b000000, 2'd0, 2'd0, 3'd0, 4'b0000, 2'd0, 3'b100};
    localparam logic [21:0] MADR_L   = {6'b000000, 2'd2, 2'd1, 3'd0, 4'b0000, 2'd0, 3'b000};
    localparam logic [21:0] MADR_S   = {6'b000000, 2'd2, 2'd1, 3'd1, 4'b0000, 2'd0, 3'b000};
    localparam logic [21:0] MRD      = {6'b101000, 2'd0, 2'd0, 3'd0, 4'b0000, 2'd0, 3'b000};
    localparam logic [21:0] MWR      = {6'b111000, 2'd0, 2'd0, 3'd0, 4'b0000, 2'd0, 3'b000};
    localparam logic [21:0] MWB      = {6'b000000, 2'd0, 2'd0, 3'd0, 4'b0000, 2'd1, 3'b100};
    localparam logic [21:0] BR_EQ_T  = {6'b000011, 2'd2, 2'd0, 3'd0, 4'b1000, 2'd0, 3'b000};
    localparam logic [21:0] BR_EQ_N  = {6'b000001, 2'd2, 2'd0, 3'd0, 4'b1000, 2'd0, 3'b000};
    localparam logic [21:0] BR_LT_T  = {6'b000011, 2'd2, 2'd0, 3'd0, 4'b0010, 2'd0, 3'b000};
    localparam logic [21:0] JALR_T   = {6'b000000, 2'd2, 2'd1, 3'd0, 4'b0000, 2'd0, 3'b000};
    localparam logic [21:0] JLINK    = {6'b000011, 2'd1, 2'd2, 3'd0, 4'b0000, 2'd2, 3'b100};
    localparam logic [21:0] LUI_S    = {6'b000000, 2'd0, 2'd0, 3'd4, 4'b0000, 2'd3, 3'b100};

    logic        clk;
    logic        rstn;
    logic [31:0] instr;
    logic        zero;
    logic        ready;
    logic        mem_req, mem_wr_en, adr_src, ir_wr_en, pc_wr_en, src_pc;
    logic [1:0]  src_alu_a, src_alu_b, src_rd;
    logic [2:0]  src_imm;
    logic [3:0]  alu_ctrl;
    logic        reg_wr_en, illegal, mem_err;
    logic [21:0] outs;

    int errors = 0;
    int checks = 0;

    riscv_mc_ctrl #(.MEM_TIMEOUT(4)) dut (
        .i_clk            (clk),
        .i_rstn           (rstn),
        .i_ctrl_instr     (instr),
        .i_ctrl_alu_zero  (zero),
        .i_ctrl_mem_ready (ready),
        .o_ctrl_mem_req   (mem_req),
        .o_ctrl_mem_wr_en (mem_wr_en),
        .o_ctrl_adr_src   (adr_src),
        .o_ctrl_ir_wr_en  (ir_wr_en),
        .o_ctrl_pc_wr_en  (pc_wr_en),
        .o_ctrl_src_pc    (src_pc),
        .o_ctrl_src_alu_a (src_alu_a),
        .o_ctrl_src_alu_b (src_alu_b),
        .o_ctrl_src_imm   (src_imm),
        .o_ctrl_alu_ctrl  (alu_ctrl),
        .o_ctrl_src_rd    (src_rd),
        .o_ctrl_reg_wr_en (reg_wr_en),
        .o_ctrl_illegal   (illegal),
        .o_ctrl_mem_err   (mem_err)
    );

    assign outs = {mem_req, mem_wr_en, adr_src, ir_wr_en, pc_wr_en, src_pc,
                   src_alu_a, src_alu_b, src_imm, alu_ctrl, src_rd,
                   reg_wr_en, illegal, mem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rstn = 1'b0; ready = 1'b1; zero = 1'b0; instr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            checks++;
            if (outs !== 22'h0) begin errors++; $display("FAIL reset_hold cyc%0d: got %h want %h", i, outs, 22'h0); end
        end
        rstn = 1'b1; #1;
        checks++;
        if (outs !== 22'h0) begin errors++; $display("FAIL reset_release: got %h want %h", outs, 22'h0); end
        next_cycle(); ready = 1'b0; #1;
        checks++;
        if (outs !== F_WAIT) begin errors++; $display("FAIL reset_first_fetch: got %h want %h", outs, F_WAIT); end
        next_cycle();
    endtask

    task automatic test_add();
        logic [21:0] ev [4] = '{F_RDY, DEC_I, EXR_ADD, ALUWB};
        instr = 32'h002081B3; ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs !== ev[i]) begin errors++; $display("FAIL add cyc%0d: got %h want %h", i, outs, ev[i]); end
            next_cycle();
        end
    endtask

    task automatic test_load_wait();
        logic [21:0] ev  [7] = '{F_RDY, DEC_I, MADR_L, MRD, MRD, MRD, MWB};
        logic        rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        instr = 32'h0080A283;
        for (int i = 0; i < 7; i++) begin
            ready = rdy[i]; #1;
            checks++;
            if (outs !== ev[i]) begin errors++; $display("FAIL load_wait cyc%0d: got %h want %h", i, outs, ev[i]); end
            next_cycle();
        end
    endtask

    task automatic test_itype();
        logic [31:0] ins [2] = '{32'h40315093, 32'hC0010093};
        logic [21:0] ex  [2] = '{EXI_SRAI, EXI_ADDI};
        ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            logic [21:0] ev [4];
            ev = '{F_RDY, DEC_I, ex[k], ALUWB};
            instr = ins[k];
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++;
                if (outs !== ev[i]) begin errors++; $display("FAIL itype%0d cyc%0d: got %h want %h", k, i, outs, ev[i]); end
                next_cycle();
            end
        end
    endtask

    task automatic test_branches();
        logic [31:0] ins [4] = '{32'h00208463, 32'h00209463, 32'h0020C463, 32'h00208463};
        logic        zr  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [21:0] bx  [4] = '{BR_EQ_T, BR_EQ_N, BR_LT_T, BR_EQ_N};
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [21:0] ev [3];
            ev = '{F_RDY, DEC_B, bx[k]};
            instr = ins[k];
            for (int i = 0; i < 3; i++) begin
                zero = (i == 2) ? zr[k] : ~zr[k];
                #1;
                checks++;
                if (outs !== ev[i]) begin errors++; $display("FAIL branch%0d cyc%0d: got %h want %h", k, i, outs, ev[i]); end
                next_cycle();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jumps();
        logic [31:0] ins [7] = '{32'h008000EF, 32'h008000EF, 32'h008000EF,
                                 32'h000100E7, 32'h000100E7, 32'h000100E7, 32'h000100E7};
        logic [21:0] ev  [7] = '{F_RDY, DEC_J, JLINK, F_RDY, DEC_I, JALR_T, JLINK};
        ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            instr = ins[i]; #1;
            checks++;
            if (outs !== ev[i]) begin errors++; $display("FAIL jumps cyc%0d: got %h want %h", i, outs, ev[i]); end
            next_cycle();
        end
    endtask

    task automatic test_lui_auipc();
        logic [31:0] ins [6] = '{32'h123450B7, 32'h123450B7, 32'h123450B7,
                                 32'h00001097, 32'h00001097, 32'h00001097};
        logic [21:0] ev  [6] = '{F_RDY, DEC_I, LUI_S, F_RDY, DEC_U, ALUWB};
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            instr = ins[i]; #1;
            checks++;
            if (outs !== ev[i]) begin errors++; $display("FAIL lui_auipc cyc%0d: got %h want %h", i, outs, ev[i]); end
            next_cycle();
        end
    endtask

    // Waits split across FETCH and MEMREAD must not add up to a timeout.
    task automatic test_counter_clear();
        logic [21:0] ev  [10] = '{F_WAIT, F_WAIT, F_RDY, DEC_I, MADR_L, MRD, MRD, MRD, MRD, MWB};
        logic        rdy [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        instr = 32'h0080A283;
        for (int i = 0; i < 10; i++) begin
            ready = rdy[i]; #1;
            checks++;
            if (outs !== ev[i]) begin errors++; $display("FAIL counter_clear cyc%0d: got %h want %h", i, outs, ev[i]); end
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        logic [21:0] ev  [7] = '{F_WAIT, F_WAIT, F_WAIT, F_TOUT, F_WAIT, F_RDY, DEC_I};
        logic        rdy [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        instr = 32'h0000000F;
        for (int i = 0; i < 7; i++) begin
            ready = rdy[i]; #1;
            checks++;
            if (outs !== ev[i]) begin errors++; $display("FAIL timeout cyc%0d: got %h want %h", i, outs, ev[i]); end
            next_cycle();
        end
    endtask

    task automatic test_illegal();
        logic [21:0] ev [3] = '{F_RDY, DEC_ILL, F_WAIT};
        logic        rdy [3] = '{1'b1, 1'b1, 1'b0};
        instr = 32'h0000007F;
        for (int i = 0; i < 3; i++) begin
            ready = rdy[i]; #1;
            checks++;
            if (outs !== ev[i]) begin errors++; $display("FAIL illegal cyc%0d: got %h want %h", i, outs, ev[i]); end
            next_cycle();
        end
        ready = 1'b1; #1;
        checks++;
        if (outs !== F_RDY) begin errors++; $display("FAIL illegal_refetch: got %h want %h", outs, F_RDY); end
        next_cycle();
        #1;
        checks++;
        if (outs !== DEC_ILL) begin errors++; $display("FAIL illegal_again: got %h want %h", outs, DEC_ILL); end
        next_cycle();
    endtask

    task automatic test_reset_mid_write();
        logic [21:0] ev  [4] = '{F_RDY, DEC_I, MADR_S, MWR};
        logic        rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        instr = 32'h0020A223;
        for (int i = 0; i < 4; i++) begin
            ready = rdy[i]; #1;
            checks++;
            if (outs !== ev[i]) begin errors++; $display("FAIL store cyc%0d: got %h want %h", i, outs, ev[i]); end
            next_cycle();
        end
        #1;
        checks++;
        if (outs !== MWR) begin errors++; $display("FAIL store_wait2: got %h want %h", outs, MWR); end
        rstn = 1'b0; #1;
        checks++;
        if (outs !== 22'h0) begin errors++; $display("FAIL reset_mid_write: got %h want %h", outs, 22'h0); end
        ready = 1'b1;
        next_cycle(); #1;
        checks++;
        if (outs !== 22'h0) begin errors++; $display("FAIL reset_mid_write_hold: got %h want %h", outs, 22'h0); end
        rstn = 1'b1; #1;
        checks++;
        if (outs !== 22'h0) begin errors++; $display("FAIL reset_mid_write_release: got %h want %h", outs, 22'h0); end
        next_cycle(); #1;
        checks++;
        if (outs !== F_RDY) begin errors++; $display("FAIL reset_mid_write_fetch: got %h want %h", outs, F_RDY); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_itype();
        test_branches();
        test_jumps();
        test_lui_auipc();
        test_counter_clear();
        test_timeout();
        test_illegal();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
